// File: rtl/bram_accum_rmw.sv
// Accumulating BRAM: pipelined read-modify-write port with forwarding and saturation,
// an independent read-first read port, and a sweep that zeros memory after reset or on clear_req.
module bram_accum_rmw #(
  parameter int  RAM_WIDTH = 8,
  parameter int  RAM_DEPTH = 64,
  parameter int  OUT_REG   = 1,
  parameter int  SATURATE  = 1,
  localparam int ADDR_W    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_req,
  output logic                 busy,
  input  logic                 op_valid,
  input  logic                 op_mode,
  input  logic [ADDR_W-1:0]    op_addr,
  input  logic [RAM_WIDTH-1:0] op_data,
  output logic                 ovf,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic                 rd_valid,
  output logic [RAM_WIDTH-1:0] rd_data
);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  localparam logic [ADDR_W:0]      DEPTH_X   = RAM_DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);
  localparam logic [RAM_WIDTH-1:0] SMAX      = {1'b0, {(RAM_WIDTH-1){1'b1}}};
  localparam logic [RAM_WIDTH-1:0] SMIN      = {1'b1, {(RAM_WIDTH-1){1'b0}}};

  logic [RAM_WIDTH-1:0] ram [RAM_DEPTH];

  state_t               state;
  logic [ADDR_W-1:0]    cnt;
  logic                 op_acc;
  logic                 rd_acc;
  logic                 s1_vld;
  logic                 s1_mode;
  logic [ADDR_W-1:0]    s1_addr;
  logic [RAM_WIDTH-1:0] s1_data;
  logic [RAM_WIDTH-1:0] s1_old;
  logic [RAM_WIDTH-1:0] s1_new;
  logic [RAM_WIDTH:0]   sum;
  logic                 s1_oor;
  logic                 fwd_hit;
  logic [RAM_WIDTH-1:0] op_raw;
  logic [RAM_WIDTH-1:0] rd_raw;
  logic                 rd1_vld;
  logic [RAM_WIDTH-1:0] rd1_dat;
  logic                 ram_we;
  logic [ADDR_W-1:0]    ram_wa;
  logic [RAM_WIDTH-1:0] ram_wd;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_X;
  endfunction

  assign op_acc  = op_valid & ~busy;
  assign rd_acc  = rd_en & ~busy;
  assign op_raw  = in_range(op_addr) ? ram[op_addr] : '0;
  assign rd_raw  = in_range(rd_addr) ? ram[rd_addr] : '0;
  // The S1 result is written at the same edge this op samples the array, so take it directly.
  assign fwd_hit = s1_vld && (s1_addr == op_addr) && in_range(s1_addr);

  always_comb begin
    sum    = {s1_old[RAM_WIDTH-1], s1_old} + {s1_data[RAM_WIDTH-1], s1_data};
    s1_oor = s1_mode & (sum[RAM_WIDTH] ^ sum[RAM_WIDTH-1]);
    s1_new = s1_data;
    if (s1_mode) begin
      if (s1_oor && (SATURATE != 0)) s1_new = sum[RAM_WIDTH] ? SMIN : SMAX;
      else                           s1_new = sum[RAM_WIDTH-1:0];
    end
  end

  // The sweep owns the write port; an S1 write-back landing in CLEAR is zeroed by the sweep anyway.
  always_comb begin
    ram_we = 1'b0;
    ram_wa = s1_addr;
    ram_wd = s1_new;
    if (rst) begin
      ram_we = 1'b0;
    end else if (state == ST_CLEAR) begin
      ram_we = 1'b1;
      ram_wa = cnt;
      ram_wd = '0;
    end else if (s1_vld && in_range(s1_addr)) begin
      ram_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_wa] <= ram_wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (cnt == LAST_ADDR) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (clear_req) begin
            state <= ST_CLEAR;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_CLEAR;
          busy  <= 1'b1;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_mode <= 1'b0;
      s1_addr <= '0;
      s1_data <= '0;
      s1_old  <= '0;
      ovf     <= 1'b0;
      rd1_vld <= 1'b0;
      rd1_dat <= '0;
    end else begin
      s1_vld <= op_acc;
      if (op_acc) begin
        s1_mode <= op_mode;
        s1_addr <= op_addr;
        s1_data <= op_data;
        s1_old  <= fwd_hit ? s1_new : op_raw;
      end
      ovf     <= s1_vld & s1_oor;
      rd1_vld <= rd_acc;
      if (rd_acc) rd1_dat <= rd_raw;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_valid <= 1'b0;
          rd_data  <= '0;
        end else begin
          rd_valid <= rd1_vld;
          if (rd1_vld) rd_data <= rd1_dat;
        end
      end
    end else begin : g_noreg
      assign rd_valid = rd1_vld;
      assign rd_data  = rd1_dat;
    end
  endgenerate

endmodule

// File: tb/tb_bram_accum_rmw.sv
// Bench: two instances (OUT_REG=1/SATURATE=1 and OUT_REG=0/SATURATE=0) driven identically,
// checked every cycle against a program-order memory model plus literal expectations.
module tb_bram_accum_rmw;
  localparam int W  = 8;
  localparam int D  = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear_req = 1'b0;
  logic          op_valid = 1'b0;
  logic          op_mode = 1'b0;
  logic [AW-1:0] op_addr = '0;
  logic [W-1:0]  op_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [1:0]    busy_v, ovf_v, rv_v;
  logic [W-1:0]  rdd [2];

  always #5 clk = ~clk;

  bram_accum_rmw #(.RAM_WIDTH(W), .RAM_DEPTH(D), .OUT_REG(1), .SATURATE(1)) u0 (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy_v[0]),
    .op_valid(op_valid), .op_mode(op_mode), .op_addr(op_addr), .op_data(op_data),
    .ovf(ovf_v[0]), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rv_v[0]), .rd_data(rdd[0]));

  bram_accum_rmw #(.RAM_WIDTH(W), .RAM_DEPTH(D), .OUT_REG(0), .SATURATE(0)) u1 (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy_v[1]),
    .op_valid(op_valid), .op_mode(op_mode), .op_addr(op_addr), .op_data(op_data),
    .ovf(ovf_v[1]), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rv_v[1]), .rd_data(rdd[1]));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat [2] = '{2, 1};
  bit sat [2] = '{1'b1, 1'b0};

  // lmem: contents in op order (what the next op sees); cmem: what a read port sees
  int lmem [2][D];
  int cmem [2][D];
  int mbusy = D;
  bit pend_v = 1'b0;
  int pend_a = 0;
  int pend_d [2];
  bit sv [2][16];
  int sd [2][16];
  bit so [2][16];
  int held [2] = '{0, 0};
  int ovf_n [2] = '{0, 0};
  int qd0 [$], qc0 [$], qd1 [$], qc1 [$];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit bz, o;
    int s, old, nv;
    if (rst) begin
      mbusy  = D;
      pend_v = 1'b0;
      for (int i = 0; i < 2; i++) begin
        held[i] = 0;
        for (int k = 0; k < 16; k++) begin sv[i][k] = 1'b0; so[i][k] = 1'b0; end
      end
    end else begin
      bz = (mbusy > 0);
      if (!bz && rd_en)
        for (int i = 0; i < 2; i++) begin
          sv[i][(cyc + lat[i]) % 16] = 1'b1;
          sd[i][(cyc + lat[i]) % 16] = cmem[i][rd_addr];
        end
      if (pend_v)
        for (int i = 0; i < 2; i++) cmem[i][pend_a] = pend_d[i];
      pend_v = 1'b0;
      if (!bz && op_valid) begin
        for (int i = 0; i < 2; i++) begin
          old = lmem[i][op_addr];
          o   = 1'b0;
          if (op_mode) begin
            s = old + int'($signed(op_data));
            o = (s > 127) || (s < -128);
            if (!o)          nv = s;
            else if (sat[i]) nv = (s > 127) ? 127 : -128;
            else             nv = (s > 127) ? s - 256 : s + 256;
          end else begin
            nv = int'($signed(op_data));
          end
          lmem[i][op_addr] = nv;
          pend_d[i] = nv;
          if (o) so[i][(cyc + 2) % 16] = 1'b1;
        end
        pend_v = 1'b1;
        pend_a = int'(op_addr);
      end
      if (bz) begin
        mbusy--;
        if (mbusy == 0)
          for (int i = 0; i < 2; i++)
            for (int a = 0; a < D; a++) begin lmem[i][a] = 0; cmem[i][a] = 0; end
      end else if (clear_req) begin
        mbusy = D;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin : compare
    int slot;
    slot = cyc % 16;
    for (int i = 0; i < 2; i++) begin
      bit eb, eo, ev;
      if (rst) begin
        eb = 1'b1; eo = 1'b0; ev = 1'b0; held[i] = 0;
      end else begin
        eb = (mbusy > 0); eo = so[i][slot]; ev = sv[i][slot];
        if (ev) held[i] = sd[i][slot];
      end
      so[i][slot] = 1'b0;
      sv[i][slot] = 1'b0;
      chk($sformatf("busy%0d", i), int'(busy_v[i]), int'(eb));
      chk($sformatf("ovf%0d", i), int'(ovf_v[i]), int'(eo));
      chk($sformatf("rd_valid%0d", i), int'(rv_v[i]), int'(ev));
      chk($sformatf("rd_data%0d", i), int'($signed(rdd[i])), held[i]);
      if (ovf_v[i]) ovf_n[i]++;
    end
    if (rv_v[0]) begin qd0.push_back(int'($signed(rdd[0]))); qc0.push_back(cyc); end
    if (rv_v[1]) begin qd1.push_back(int'($signed(rdd[1]))); qc1.push_back(cyc); end
  end

  task automatic cyc_in(bit ov, bit om, int oa, int od, bit re, int ra, bit cr);
    op_valid = ov; op_mode = om; op_addr = AW'(oa); op_data = W'(od);
    rd_en = re; rd_addr = AW'(ra); clear_req = cr;
    @(posedge clk); #1;
    op_valid = 1'b0; rd_en = 1'b0; clear_req = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(int a, int d);  cyc_in(1'b1, 1'b0, a, d, 1'b0, 0, 1'b0); endtask
  task automatic acc(int a, int d); cyc_in(1'b1, 1'b1, a, d, 1'b0, 0, 1'b0); endtask
  task automatic rd(int a);         cyc_in(1'b0, 1'b0, 0, 0, 1'b1, a, 1'b0); endtask

  task automatic clr_q();
    qd0.delete(); qc0.delete(); qd1.delete(); qc1.delete();
  endtask

  // pops the oldest result of each instance for a read issued in cycle ic
  task automatic chk_rd(string name, int ic, int e0, int e1);
    if (qd0.size() == 0) chk({name, "_missing0"}, 0, 1);
    else begin
      chk({name, "_dat0"}, qd0.pop_front(), e0);
      chk({name, "_lat0"}, qc0.pop_front() - ic, 2);
    end
    if (qd1.size() == 0) chk({name, "_missing1"}, 0, 1);
    else begin
      chk({name, "_dat1"}, qd1.pop_front(), e1);
      chk({name, "_lat1"}, qc1.pop_front() - ic, 1);
    end
  endtask

  task automatic busy_len(string name, bit drive);
    int n;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy_v[0]) break;
      n++;
      @(posedge clk); #1;
      if (drive && n < 60) begin
        op_valid = 1'b1; op_mode = 1'b0; op_addr = AW'(k); op_data = 8'h5A;
        rd_en = 1'b1; rd_addr = AW'(k);
      end else begin
        op_valid = 1'b0; rd_en = 1'b0;
      end
    end
    op_valid = 1'b0; rd_en = 1'b0;
    chk(name, n, D);
    @(posedge clk); #1;
  endtask

  task automatic read_all_zero(string name);
    int ic0, nz;
    clr_q();
    ic0 = cyc;
    for (int a = 0; a < D; a++) rd(a);
    idle(3);
    chk({name, "_n0"}, qd0.size(), D);
    chk({name, "_n1"}, qd1.size(), D);
    nz = 0;
    foreach (qd0[k]) if (qd0[k] != 0) nz++;
    foreach (qd1[k]) if (qd1[k] != 0) nz++;
    chk({name, "_nonzero"}, nz, 0);
    if (qc0.size() > 0) chk({name, "_lat0"}, qc0[0] - ic0, 2);
    if (qc1.size() > 0) chk({name, "_lat1"}, qc1[0] - ic0, 1);
    clr_q();
  endtask

  initial begin
    int ic, ic2, o0, o1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy_v[0]), 1);
    chk("rst_rd_valid", int'(rv_v[0]), 0);
    chk("rst_rd_data", int'(rdd[0]), 0);
    chk("rst_ovf", int'(ovf_v[0]), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: sweep after reset, everything reads zero
    busy_len("busy_after_rst", 1'b0);
    read_all_zero("init");

    // 2: overwrite then back-to-back accumulates through forwarding
    o0 = ovf_n[0]; o1 = ovf_n[1];
    wr(5, 10); acc(5, 3); acc(5, 3); acc(5, 3);
    idle(2);
    chk("t2_ovf0", ovf_n[0] - o0, 0);
    chk("t2_ovf1", ovf_n[1] - o1, 0);
    ic = cyc; rd(5); idle(2);
    chk_rd("t2_addr5", ic, 19, 19);

    // 3: saturation vs wrap at both ends of the range
    o0 = ovf_n[0]; o1 = ovf_n[1];
    wr(2, 120); acc(2, 20); wr(3, -120); acc(3, -20);
    idle(3);
    chk("t3_ovf0", ovf_n[0] - o0, 2);
    chk("t3_ovf1", ovf_n[1] - o1, 2);
    ic = cyc; rd(2); idle(2);
    chk_rd("t3_addr2", ic, 127, -116);
    ic = cyc; rd(3); idle(2);
    chk_rd("t3_addr3", ic, -128, 116);

    // 4: read colliding with a write-back is read-first
    wr(7, 4); idle(2);
    acc(7, 5);
    ic = cyc;  rd(7);
    ic2 = cyc; rd(7);
    idle(3);
    chk_rd("t4_same_cycle", ic, 4, 4);
    chk_rd("t4_next_cycle", ic2, 9, 9);

    // 5: clear_req together with an op and an in-flight read
    wr(0, 11); wr(1, 22); wr(63, -5); idle(2);
    clr_q();
    ic = cyc;
    cyc_in(1'b1, 1'b0, 0, 55, 1'b1, 1, 1'b1);
    busy_len("busy_after_clear", 1'b1);
    chk_rd("t5_inflight", ic, 22, 22);
    chk("t5_dropped_rd0", qd0.size(), 0);
    chk("t5_dropped_rd1", qd1.size(), 0);
    read_all_zero("after_clear");

    // 6: reset in the middle of an accumulate/read stream
    for (int k = 0; k < 6; k++) cyc_in(1'b1, 1'b1, 9, 100, 1'b1, 9, 1'b0);
    op_valid = 1'b1; op_mode = 1'b1; op_addr = AW'(9); op_data = W'(100);
    rd_en = 1'b1; rd_addr = AW'(9);
    rst = 1'b1;
    #1;
    chk("t6_rd_valid0", int'(rv_v[0]), 0);
    chk("t6_rd_valid1", int'(rv_v[1]), 0);
    chk("t6_ovf0", int'(ovf_v[0]), 0);
    chk("t6_ovf1", int'(ovf_v[1]), 0);
    @(posedge clk); #1;
    rst = 1'b0; op_valid = 1'b0; rd_en = 1'b0;
    busy_len("busy_after_midrst", 1'b0);
    read_all_zero("after_midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
